cmd_card_responder: RTL and testbench
=====================================

CMD_CARD_RESPONDER -- requirements
Module: cmd_card_responder

Interface
REQ-001 SHALL have parameter NCR, default 2, meaning clock cycles between the command end bit and the response start bit (legal 2..64).
REQ-002 SHALL have port CLK_SD_card, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cmd_in, input, 1, CMD line as seen by the card, idle high.
REQ-005 SHALL have port card_status, input, 32, R1 status word, sampled on acceptance of a command.
REQ-006 SHALL have port cmd_out, output, 1, serial response bit, MSB first.
REQ-007 SHALL have port cmd_oe, output, 1, response output enable.
REQ-008 SHALL have port cmd_valid, output, 1, one-cycle pulse on acceptance of a command.
REQ-009 SHALL have port cmd_index, output, 6, index of the last accepted command.
REQ-010 SHALL have port cmd_arg, output, 32, argument of the last accepted command.
REQ-011 SHALL have port crc_error, output, 1, one-cycle pulse on a CRC7 mismatch.
REQ-012 SHALL have port frame_error, output, 1, one-cycle pulse on a bad transmission or end bit.
REQ-013 SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, RECV, WAIT, SEND.
REQ-015 IDLE SHALL go to RECV when cmd_in is sampled 0 (start bit); the bit counter SHALL then load 1.
REQ-016 RECV SHALL shift cmd_in into a 48-bit register; the frame is complete when the 48th bit is sampled (counter 47).
REQ-017 Frame format: start 0, transmission bit 1, index[5:0], arg[31:0], CRC7 over the first 40 bits, end bit 1.
REQ-018 A frame SHALL be accepted when the transmission bit is 1, the end bit is 1 and the CRC matches; otherwise it SHALL be rejected.
REQ-019 A frame with transmission bit 0 or end bit 0 SHALL pulse frame_error and return to IDLE with no response.
REQ-020 On acceptance, cmd_valid SHALL pulse on the cycle after the end bit; cmd_index and cmd_arg SHALL update and card_status SHALL be latched on that same cycle.
REQ-021 An accepted frame with index 0 SHALL return to IDLE with no response; every other index SHALL enter WAIT.
REQ-022 WAIT SHALL count NCR cycles; the response start bit SHALL appear on cmd_out on cycle E+NCR+1, where E is the end-bit sample cycle.
REQ-023 SEND SHALL drive 48 bits: start 0, transmission 0, echoed index, latched status, CRC7 computed over the first 40 bits, end 1.
REQ-024 cmd_oe SHALL be high exactly for those 48 cycles; while cmd_oe is low, cmd_out SHALL be 1.
REQ-025 After the end bit the block SHALL return to IDLE; cmd_in SHALL be ignored during WAIT and SEND.
REQ-026 CRC7 SHALL use polynomial x^7+x^3+1 with a zero seed and be computed serially, one bit per cycle.

Reset
REQ-027 Asserting reset at any time, including mid-RECV or mid-SEND, SHALL force IDLE within the same cycle (asynchronously).
REQ-028 During reset: cmd_out=1, cmd_oe=0, cmd_valid=0, crc_error=0, frame_error=0, busy=0, cmd_index=0, cmd_arg=0, counters and CRC registers 0.
REQ-029 After deassertion, the first start bit SHALL be recognised on the first rising edge.

Configuration
REQ-030 Macro CMD_CARD_CRC_CHECK_EN: when defined, the received CRC7 SHALL be checked; on mismatch crc_error SHALL pulse, there SHALL be no cmd_valid and no response, and the block SHALL return to IDLE.
REQ-031 Without the macro, the received CRC SHALL be ignored and crc_error SHALL be tied 0; response CRC generation SHALL remain present.

Structure
REQ-032 The shared package SHALL hold the frame length (48), the CRC7 polynomial (7'h09), the transmission-bit constants and the state encoding.
REQ-033 A sub-module cmd_crc7 (serial CRC7 with clear, enable, data in and crc[6:0] out) SHALL be instantiated twice: once for RX and once for TX.

Verification
REQ-034 CMD8 frame 0x48000001AA87, NCR=2 -> cmd_valid pulse, index 8, arg 0x000001AA; response starts at E+3.
REQ-035 CMD17 frame 0x510000000055, card_status 0x00000900 -> cmd_out sequence 0x110000090067, with cmd_oe high for 48 cycles.
REQ-036 CMD0 frame 0x400000000095 -> cmd_valid pulse, index 0, cmd_oe never asserted.
REQ-037 CMD8 with CRC byte 0x89 under CMD_CARD_CRC_CHECK_EN -> crc_error pulse, no cmd_valid, no response; without the macro -> normal response.
REQ-038 Frame with end bit 0 -> frame_error pulse, then IDLE; reset asserted at bit 20 of SEND -> cmd_oe=0 and cmd_out=1 immediately, and the next valid command receives a full response.

Source files
------------

// File: rtl/cmd_card_responder_pkg.sv
// Shared constants, state encoding and the CRC7 step function for the SD-card
// command responder.
package cmd_card_responder_pkg;

    localparam int         FRAME_LEN   = 48;
    localparam int         PAYLOAD_LEN = 40;
    localparam logic [6:0] CRC7_POLY   = 7'h09;
    localparam logic       START_BIT   = 1'b0;
    localparam logic       END_BIT     = 1'b1;
    localparam logic       TX_BIT_HOST = 1'b1;
    localparam logic       TX_BIT_CARD = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WAIT,
        ST_SEND
    } state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/cmd_card_responder_crc7.sv
// Serial CRC7 (x^7+x^3+1, zero seed): one bit per enabled cycle, synchronous
// clear has priority over enable.
module cmd_crc7
    import cmd_card_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            crc <= '0;
        else if (clr)
            crc <= '0;
        else if (en)
            crc <= crc7_step(crc, din);
    end

endmodule

// File: rtl/cmd_card_responder.sv
// SD-card CMD-line responder: receives 48-bit command frames and answers with
// an R1-style response NCR cycles later. Define CMD_CARD_CRC_CHECK_EN to check
// the received CRC7.
module cmd_card_responder
    import cmd_card_responder_pkg::*;
#(
    parameter int NCR = 2
) (
    input  logic        CLK_SD_card,
    input  logic        reset,
    input  logic        cmd_in,
    input  logic [31:0] card_status,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        crc_error,
    output logic        frame_error,
    output logic        busy
);

    state_t      state, state_next;
    logic [5:0]  bit_cnt;
    logic [45:0] rx_sr;
    logic [6:0]  wait_cnt;
    logic [5:0]  tx_cnt;
    logic [39:0] tx_sr;
    logic [6:0]  rx_crc, tx_crc;

    // Frame bits 1..47 as seen on the end-bit edge: [46] transmission bit,
    // [45:40] index, [39:8] argument, [7:1] CRC7, [0] end bit.
    logic [46:0] frame;
    logic        frame_done, frame_bad, crc_bad, accept;

    assign frame      = {rx_sr, cmd_in};
    assign frame_done = (state == ST_RECV) && (bit_cnt == 6'(FRAME_LEN - 1));
    assign frame_bad  = frame_done && ((frame[46] != TX_BIT_HOST) || (frame[0] != END_BIT));

`ifdef CMD_CARD_CRC_CHECK_EN
    assign crc_bad = frame_done && !frame_bad && (frame[7:1] != rx_crc);

    always_ff @(posedge CLK_SD_card or posedge reset) begin
        if (reset)
            crc_error <= 1'b0;
        else
            crc_error <= crc_bad;
    end
`else
    logic crc_unused;
    assign crc_unused = ^{frame[7:1], rx_crc};
    assign crc_bad    = 1'b0;
    assign crc_error  = 1'b0;
`endif

    assign accept = frame_done && !frame_bad && !crc_bad;

    cmd_crc7 u_rx_crc (
        .clk   (CLK_SD_card),
        .reset (reset),
        .clr   (state == ST_IDLE),
        .en    ((state == ST_RECV) && (bit_cnt <= 6'(PAYLOAD_LEN - 1))),
        .din   (cmd_in),
        .crc   (rx_crc)
    );

    // Past the payload the CRC register is fed its own MSB, which zeroes the
    // feedback and turns it into a plain shifter for the CRC field.
    cmd_crc7 u_tx_crc (
        .clk   (CLK_SD_card),
        .reset (reset),
        .clr   (state != ST_SEND),
        .en    ((state == ST_SEND) && (tx_cnt != 6'(FRAME_LEN - 1))),
        .din   (cmd_out),
        .crc   (tx_crc)
    );

    always_ff @(posedge CLK_SD_card or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cmd_oe     = 1'b0;
        cmd_out    = 1'b1;
        busy       = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: if (cmd_in == START_BIT) state_next = ST_RECV;
            ST_RECV: begin
                if (frame_done)
                    state_next = (accept && (frame[45:40] != 6'd0)) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: if (wait_cnt == 7'(NCR)) state_next = ST_SEND;
            ST_SEND: begin
                cmd_oe = 1'b1;
                if (tx_cnt < 6'(PAYLOAD_LEN))
                    cmd_out = tx_sr[39];
                else if (tx_cnt == 6'(FRAME_LEN - 1))
                    cmd_out = END_BIT;
                else
                    cmd_out = tx_crc[6];
                if (tx_cnt == 6'(FRAME_LEN - 1))
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_SD_card or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            rx_sr       <= '0;
            wait_cnt    <= '0;
            tx_cnt      <= '0;
            tx_sr       <= '0;
            cmd_valid   <= 1'b0;
            frame_error <= 1'b0;
            cmd_index   <= '0;
            cmd_arg     <= '0;
        end else begin
            cmd_valid   <= accept;
            frame_error <= frame_bad;
            if ((state == ST_IDLE) || (state == ST_RECV))
                rx_sr <= {rx_sr[44:0], cmd_in};
            if (state_next == ST_RECV)
                bit_cnt <= (state == ST_RECV) ? bit_cnt + 6'd1 : 6'd1;
            else
                bit_cnt <= '0;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 7'd1 : 7'd0;
            tx_cnt   <= (state == ST_SEND) ? tx_cnt + 6'd1 : 6'd0;
            if (accept) begin
                cmd_index <= frame[45:40];
                cmd_arg   <= frame[39:8];
                tx_sr     <= {START_BIT, TX_BIT_CARD, frame[45:40], card_status};
            end else if (state == ST_SEND) begin
                tx_sr <= {tx_sr[38:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_cmd_card_responder.sv
// Self-checking bench for cmd_card_responder: a cycle-indexed timeline model
// of expected outputs plus directed command frames with literal expectations.
module tb_cmd_card_responder;

    localparam int NCR = 2;
`ifdef CMD_CARD_CRC_CHECK_EN
    localparam bit CRC_CHECK = 1'b1;
`else
    localparam bit CRC_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_in;
    logic [31:0] card_status;
    logic        cmd_out, cmd_oe, cmd_valid, crc_error, frame_error, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    always #5 clk = ~clk;

    cmd_card_responder #(.NCR(NCR)) dut (
        .CLK_SD_card (clk),
        .reset       (reset),
        .cmd_in      (cmd_in),
        .card_status (card_status),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .crc_error   (crc_error),
        .frame_error (frame_error),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit run    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CRC7 as the remainder of d(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [46:0] r;
        logic [46:0] g;
        r = {d, 7'b0};
        g = 47'h89;
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (g << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] model_resp(input logic [5:0] idx, input logic [31:0] st);
        logic [39:0] p;
        p = {2'b00, idx, st};
        return {p, crc7(p), 1'b1};
    endfunction

    // Timeline model: cycle numbers are posedge counts; E is the end-bit edge.
    int          busy_from = 1, busy_to = 0;
    int          valid_cyc = -1, ferr_cyc = -1, cerr_cyc = -1;
    int          resp_start = -1000;
    logic [47:0] resp = '0;
    bit          pend = 1'b0;
    logic [5:0]  pend_index = '0, cur_index = '0;
    logic [31:0] pend_arg = '0, cur_arg = '0;

    task automatic clear_model();
        busy_from  = 1;
        busy_to    = 0;
        valid_cyc  = -1;
        ferr_cyc   = -1;
        cerr_cyc   = -1;
        resp_start = -1000;
    endtask

    task automatic model_frame(input logic [47:0] f, input logic [31:0] st, input int e);
        logic crc_ok;
        crc_ok = (crc7(f[47:8]) == f[7:1]);
        if (f[46] != 1'b1 || f[0] != 1'b1) begin
            ferr_cyc = e;
            busy_to  = e - 1;
        end else if (CRC_CHECK && !crc_ok) begin
            cerr_cyc = e;
            busy_to  = e - 1;
        end else begin
            valid_cyc  = e;
            pend_index = f[45:40];
            pend_arg   = f[39:8];
            pend       = 1'b1;
            if (f[45:40] == 6'd0) begin
                busy_to = e - 1;
            end else begin
                resp_start = e + NCR + 1;
                resp       = model_resp(f[45:40], st);
                busy_to    = e + NCR + 48;
            end
        end
    endtask

    // Observation counters for the directed literal checks.
    logic [47:0] rec_bits = '0;
    int rec_cnt = 0, first_oe = -1, valid_seen = 0, ferr_seen = 0, cerr_seen = 0;

    task automatic clear_rec();
        rec_bits   = '0;
        rec_cnt    = 0;
        first_oe   = -1;
        valid_seen = 0;
        ferr_seen  = 0;
        cerr_seen  = 0;
    endtask

    logic        e_out, e_oe, e_valid, e_cerr, e_ferr, e_busy;
    logic [5:0]  e_idx;
    logic [31:0] e_arg;

    always @(negedge clk) begin
        if (run) begin
            if (reset) begin
                pend      = 1'b0;
                cur_index = '0;
                cur_arg   = '0;
                e_out = 1'b1; e_oe = 1'b0; e_valid = 1'b0;
                e_cerr = 1'b0; e_ferr = 1'b0; e_busy = 1'b0;
            end else begin
                if (pend && cyc >= valid_cyc) begin
                    cur_index = pend_index;
                    cur_arg   = pend_arg;
                    pend      = 1'b0;
                end
                e_oe    = (cyc >= resp_start) && (cyc < resp_start + 48);
                e_out   = e_oe ? resp[47 - (cyc - resp_start)] : 1'b1;
                e_valid = (cyc == valid_cyc);
                e_ferr  = (cyc == ferr_cyc);
                e_cerr  = (cyc == cerr_cyc);
                e_busy  = (cyc >= busy_from) && (cyc <= busy_to);
            end
            e_idx = cur_index;
            e_arg = cur_arg;
            check("cmd_out", 64'(cmd_out), 64'(e_out));
            check("cmd_oe", 64'(cmd_oe), 64'(e_oe));
            check("cmd_valid", 64'(cmd_valid), 64'(e_valid));
            check("crc_error", 64'(crc_error), 64'(e_cerr));
            check("frame_error", 64'(frame_error), 64'(e_ferr));
            check("busy", 64'(busy), 64'(e_busy));
            check("cmd_index", 64'(cmd_index), 64'(e_idx));
            check("cmd_arg", 64'(cmd_arg), 64'(e_arg));
            if (cmd_oe === 1'b1) begin
                if (rec_cnt == 0) first_oe = cyc;
                rec_bits = {rec_bits[46:0], cmd_out};
                rec_cnt++;
            end
            if (cmd_valid === 1'b1)   valid_seen++;
            if (frame_error === 1'b1) ferr_seen++;
            if (crc_error === 1'b1)   cerr_seen++;
        end
    end

    task automatic send_frame(input logic [47:0] f, input logic [31:0] st, output int e);
        e = 0;
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            cmd_in      = f[i];
            card_status = st;
            if (i == 47) begin
                busy_from = cyc + 1;
                busy_to   = 1 << 30;
            end
            if (i == 0) begin
                e = cyc + 1;
                model_frame(f, st, e);
            end
        end
        @(negedge clk);
        cmd_in = 1'b1;
    endtask

    task automatic idle();
        repeat (NCR + 60) @(negedge clk);
    endtask

    int e;

    initial begin
        reset       = 1'b1;
        cmd_in      = 1'b1;
        card_status = '0;
        run         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_out", 64'(cmd_out), 64'd1);
        check("rst_cmd_oe", 64'(cmd_oe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_index", 64'(cmd_index), 64'd0);
        check("rst_arg", 64'(cmd_arg), 64'd0);

        check("model_crc_cmd8", 64'(crc7(40'h48000001AA)), 64'h43);
        check("model_crc_cmd0", 64'(crc7(40'h4000000000)), 64'h4A);
        check("model_resp_cmd17", 64'(model_resp(6'd17, 32'h0000_0900)), 64'h110000090067);

        @(posedge clk);
        #2 reset = 1'b0;

        // CMD8: response starts NCR+1 cycles after the end-bit edge.
        clear_rec();
        send_frame(48'h48000001AA87, 32'h0000_0120, e);
        idle();
        check("cmd8_start", 64'(first_oe), 64'(e + 3));
        check("cmd8_len", 64'(rec_cnt), 64'd48);
        check("cmd8_valid", 64'(valid_seen), 64'd1);
        check("cmd8_index", 64'(cmd_index), 64'd8);
        check("cmd8_arg", 64'(cmd_arg), 64'h0000_01AA);

        // CMD17 with noise on cmd_in while waiting/sending.
        clear_rec();
        send_frame(48'h510000000055, 32'h0000_0900, e);
        repeat (2) @(negedge clk);
        cmd_in = 1'b0;
        repeat (6) @(negedge clk);
        cmd_in = 1'b1;
        idle();
        check("cmd17_bits", 64'(rec_bits), 64'h110000090067);
        check("cmd17_len", 64'(rec_cnt), 64'd48);

        // CMD0: accepted, no response.
        clear_rec();
        send_frame(48'h400000000095, 32'h0000_0900, e);
        idle();
        check("cmd0_valid", 64'(valid_seen), 64'd1);
        check("cmd0_len", 64'(rec_cnt), 64'd0);
        check("cmd0_index", 64'(cmd_index), 64'd0);

        // CMD8 with wrong CRC.
        clear_rec();
        send_frame(48'h48000001AA89, 32'h0000_0120, e);
        idle();
        check("badcrc_crc_error", 64'(cerr_seen), CRC_CHECK ? 64'd1 : 64'd0);
        check("badcrc_valid", 64'(valid_seen), CRC_CHECK ? 64'd0 : 64'd1);
        check("badcrc_len", 64'(rec_cnt), CRC_CHECK ? 64'd0 : 64'd48);

        // End bit 0, then transmission bit 0.
        clear_rec();
        send_frame(48'h48000001AA86, 32'h0000_0120, e);
        idle();
        check("endbit_ferr", 64'(ferr_seen), 64'd1);
        check("endbit_valid", 64'(valid_seen), 64'd0);
        check("endbit_len", 64'(rec_cnt), 64'd0);
        clear_rec();
        send_frame(48'h08000001AA87, 32'h0000_0120, e);
        idle();
        check("txbit_ferr", 64'(ferr_seen), 64'd1);
        check("txbit_len", 64'(rec_cnt), 64'd0);

        // Reset at bit 20 of a CMD17 response.
        send_frame(48'h510000000055, 32'h0000_0900, e);
        repeat (NCR + 21) @(posedge clk);
        #1;
        check("pre_rst_oe", 64'(cmd_oe), 64'd1);
        check("pre_rst_bit20", 64'(cmd_out), 64'd0);
        #1;
        reset = 1'b1;
        clear_model();
        #1;
        check("rst_async_oe", 64'(cmd_oe), 64'd0);
        check("rst_async_out", 64'(cmd_out), 64'd1);
        check("rst_async_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        clear_rec();
        send_frame(48'h48000001AA87, 32'h0000_0120, e);
        idle();
        check("post_rst_start", 64'(first_oe), 64'(e + 3));
        check("post_rst_len", 64'(rec_cnt), 64'd48);
        check("post_rst_bits", 64'(rec_bits), 64'(model_resp(6'd8, 32'h0000_0120)));

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
